// File: rtl/logic_pkg.sv
// Shared helpers for the Gray-pointer FIFO: pointer code conversion and the
// read-side output buffer state type.
package logic_pkg;

    // Conversions work on any pointer up to this width; callers zero-extend in
    // and truncate the result back to their own pointer width.
    localparam int GRAY_MAX_W = 32;

    typedef enum logic [1:0] {
        BUF_EMPTY = 2'd0,
        BUF_ONE   = 2'd1,
        BUF_TWO   = 2'd2
    } buffer_state_t;

    function automatic logic [GRAY_MAX_W-1:0] bin2gray(input logic [GRAY_MAX_W-1:0] b);
        return b ^ (b >> 1);
    endfunction

    function automatic logic [GRAY_MAX_W-1:0] gray2bin(input logic [GRAY_MAX_W-1:0] g);
        logic [GRAY_MAX_W-1:0] b;
        b[GRAY_MAX_W-1] = g[GRAY_MAX_W-1];
        for (int i = GRAY_MAX_W - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    function automatic logic [1:0] buffer_occupancy(input buffer_state_t s);
        case (s)
            BUF_ONE: return 2'd1;
            BUF_TWO: return 2'd2;
            default: return 2'd0;
        endcase
    endfunction

endpackage

// File: rtl/logic_fifo_gray_read_controller_buffer.sv
// Two-entry skid buffer between the 1-cycle-latency FIFO memory and the tx stream.
// Optional checks: LOGIC_FIFO_GRAY_READ_CONTROLLER_ASSERTIONS_EN.
module logic_fifo_gray_read_controller_buffer
    import logic_pkg::*;
#(
    parameter int DATA_WIDTH = 1
) (
    input  logic                  aclk,
    input  logic                  reset,
    input  logic                  issue,
    input  logic [DATA_WIDTH-1:0] read_data,
    output logic                  tx_tvalid,
    input  logic                  tx_tready,
    output logic [DATA_WIDTH-1:0] tx_tdata,
    output buffer_state_t         state,
    output logic                  inflight
);

    // tx handshake: a beat transfers on a rising edge where tx_tvalid && tx_tready.
    // tx_tvalid is a pure function of registered state, so it never looks at tx_tready.
    logic [DATA_WIDTH-1:0] head_q;
    logic [DATA_WIDTH-1:0] skid_q;
    buffer_state_t         state_q;
    logic                  inflight_q;
    logic                  pop;

    assign tx_tvalid = (state_q != BUF_EMPTY);
    assign tx_tdata  = head_q;
    assign pop       = tx_tvalid && tx_tready;
    assign state     = state_q;
    assign inflight  = inflight_q;

    always_ff @(posedge aclk) begin
        if (reset) begin
            state_q    <= BUF_EMPTY;
            inflight_q <= 1'b0;
            head_q     <= '0;
            skid_q     <= '0;
        end else begin
            inflight_q <= issue;
            case (state_q)
                BUF_EMPTY: begin
                    if (inflight_q) begin
                        head_q  <= read_data;
                        state_q <= BUF_ONE;
                    end
                end
                BUF_ONE: begin
                    // Returning data takes the head only if the head leaves this cycle.
                    if (inflight_q && pop) begin
                        head_q <= read_data;
                    end else if (inflight_q) begin
                        skid_q  <= read_data;
                        state_q <= BUF_TWO;
                    end else if (pop) begin
                        state_q <= BUF_EMPTY;
                    end
                end
                BUF_TWO: begin
                    if (pop) begin
                        head_q <= skid_q;
                        if (inflight_q) begin
                            skid_q <= read_data;
                        end else begin
                            state_q <= BUF_ONE;
                        end
                    end
                end
                default: state_q <= BUF_EMPTY;
            endcase
        end
    end

`ifdef LOGIC_FIFO_GRAY_READ_CONTROLLER_ASSERTIONS_EN
    property p_tx_stable;
        @(posedge aclk) disable iff (reset)
        (tx_tvalid && !tx_tready) |=> (tx_tvalid && $stable(tx_tdata));
    endproperty
    a_tx_stable: assert property (p_tx_stable)
        else $error("tx_tdata/tx_tvalid changed under back-pressure");

    property p_no_overflow;
        @(posedge aclk) disable iff (reset)
        ({1'b0, buffer_occupancy(state_q)} + {2'b00, inflight_q}) <= 3'd2;
    endproperty
    a_no_overflow: assert property (p_no_overflow)
        else $error("skid buffer overflow");
`endif

endmodule

// File: rtl/logic_fifo_gray_read_controller.sv
// Read-side controller of a dual-clock Gray-pointer FIFO: pointers, level, read issue.
// Optional checks: LOGIC_FIFO_GRAY_READ_CONTROLLER_ASSERTIONS_EN.
module logic_fifo_gray_read_controller
    import logic_pkg::*;
#(
    parameter int DATA_WIDTH    = 1,
    parameter int ADDRESS_WIDTH = 8
) (
    input  logic                     aclk,
    input  logic                     reset,
    input  logic [ADDRESS_WIDTH:0]   write_pointer_synced,
    output logic                     read_enable,
    output logic [ADDRESS_WIDTH-1:0] read_address,
    input  logic [DATA_WIDTH-1:0]    read_data,
    output logic [ADDRESS_WIDTH:0]   read_pointer,
    output logic [ADDRESS_WIDTH:0]   level,
    output logic                     tx_tvalid,
    input  logic                     tx_tready,
    output logic [DATA_WIDTH-1:0]    tx_tdata
);

    localparam int PTR_W = ADDRESS_WIDTH + 1;

    logic [PTR_W-1:0] wp_gray_q;
    logic [PTR_W-1:0] wp_bin;
    logic [PTR_W-1:0] rp_bin;
    logic [PTR_W-1:0] rp_bin_next;
    logic [PTR_W-1:0] level_q;
    buffer_state_t    buf_state;
    logic             buf_inflight;
    logic             pop;
    logic             buf_has_room;

    assign wp_bin       = PTR_W'(gray2bin(GRAY_MAX_W'(wp_gray_q)));
    assign rp_bin_next  = rp_bin + PTR_W'(read_enable);
    assign read_address = rp_bin[ADDRESS_WIDTH-1:0];
    assign level        = level_q;

    // occupancy + inflight - pop < 2, rearranged so nothing goes negative.
    assign pop          = tx_tvalid && tx_tready;
    assign buf_has_room = ({1'b0, buffer_occupancy(buf_state)} + {2'b00, buf_inflight})
                          < (3'd2 + {2'b00, pop});
    assign read_enable  = !reset && (level_q != '0) && buf_has_room;

    // Level is taken against the post-issue read pointer so an issue this cycle is
    // already reflected; modular subtraction handles wrap with no special case.
    always_ff @(posedge aclk) begin
        if (reset) begin
            wp_gray_q    <= '0;
            rp_bin       <= '0;
            read_pointer <= '0;
            level_q      <= '0;
        end else begin
            wp_gray_q    <= write_pointer_synced;
            rp_bin       <= rp_bin_next;
            read_pointer <= PTR_W'(bin2gray(GRAY_MAX_W'(rp_bin_next)));
            level_q      <= wp_bin - rp_bin_next;
        end
    end

    logic_fifo_gray_read_controller_buffer #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_buffer (
        .aclk      (aclk),
        .reset     (reset),
        .issue     (read_enable),
        .read_data (read_data),
        .tx_tvalid (tx_tvalid),
        .tx_tready (tx_tready),
        .tx_tdata  (tx_tdata),
        .state     (buf_state),
        .inflight  (buf_inflight)
    );

`ifdef LOGIC_FIFO_GRAY_READ_CONTROLLER_ASSERTIONS_EN
    property p_wp_one_bit;
        @(posedge aclk) disable iff (reset)
        $countones(write_pointer_synced ^ $past(write_pointer_synced)) <= 1;
    endproperty
    a_wp_one_bit: assert property (p_wp_one_bit)
        else $error("write_pointer_synced changed by more than one bit");

    property p_level_max;
        @(posedge aclk) disable iff (reset)
        level_q <= (PTR_W'(1) << ADDRESS_WIDTH);
    endproperty
    a_level_max: assert property (p_level_max)
        else $error("level exceeds FIFO capacity");
`endif

endmodule

// File: doc/logic_fifo_gray_read_controller.md
# logic_fifo_gray_read_controller

Single-clock read-side controller for a dual-clock, Gray-pointer FIFO. It consumes the write pointer after it has been synchronized into the read clock domain and computes how many entries are available. It issues memory reads, buffers the 1-cycle-latency read data, and presents it on an AXI4-Stream-style tx interface. It also exports its Gray-coded read pointer so the write side can synchronize it back and compute fullness.

## Interface
- DATA_WIDTH, 1, width of stored words and tx_tdata.
- ADDRESS_WIDTH, 8, memory address width; FIFO capacity is 2**ADDRESS_WIDTH.
- aclk  input  1  clock; all logic on rising edge.
- reset  input  1  synchronous, active-high reset.
- write_pointer_synced  input  ADDRESS_WIDTH+1  Gray-coded write pointer, already synchronized to aclk; the extra MSB is the wrap bit.
- read_enable  output  1  memory read strobe.
- read_address  output  ADDRESS_WIDTH  memory read address.
- read_data  input  DATA_WIDTH  memory data, valid exactly 1 cycle after read_enable.
- read_pointer  output  ADDRESS_WIDTH+1  registered Gray-coded read pointer for the write domain.
- level  output  ADDRESS_WIDTH+1  entries present in the FIFO memory and not yet read.
- tx_tvalid  output  1  output data valid.
- tx_tready  input  1  downstream ready.
- tx_tdata  output  DATA_WIDTH  output data.

## Operation
- **Write pointer capture.** write_pointer_synced is registered once, then converted Gray to binary (wp_bin).
- **Read pointer.** rp_bin is an ADDRESS_WIDTH+1 binary counter.
  - read_address = rp_bin[ADDRESS_WIDTH-1:0].
  - read_pointer is the registered bin2gray of rp_bin.
- **Level.** level = wp_bin - rp_bin, modulo 2**(ADDRESS_WIDTH+1). Registered; never exceeds 2**ADDRESS_WIDTH in legal operation.
- **Output buffer.** A 2-entry skid buffer holds fetched data. Its states are:
  - EMPTY: tx_tvalid=0.
  - ONE: head valid, tx_tvalid=1.
  - TWO: head and skid valid, tx_tvalid=1.
  - An inflight flag marks a read whose data returns next cycle.
- **Read issue.** read_enable = !reset && level!=0 && (occupancy + inflight - pop) < 2, where pop = tx_tvalid && tx_tready.
  - On read_enable, rp_bin increments and level decrements by one.
- **Data return.** Returning data is written into the head if the head is free or being popped this cycle, otherwise into the skid slot. Data order is strictly preserved.
- **Stream rules.**
  - tx_tdata and tx_tvalid hold stable while tx_tvalid && !tx_tready.
  - tx_tvalid never depends combinationally on tx_tready.
- **Pointer wrap.** rp_bin wraps from 2**(ADDRESS_WIDTH+1)-1 to 0 naturally, with no special case.
- **Simultaneous events.** A pop, a data return and a new read issue may all occur in one cycle. Occupancy is updated as +return -pop.
- **Reset.** The following all go to 0 on the next edge: tx_tvalid, tx_tdata, read_address, read_pointer, level, rp_bin, the captured write pointer, inflight, and the buffer state (EMPTY).
  - read_enable is forced 0 while reset is high.
  - Data in flight during reset is discarded.

## Timing
- Write-pointer update to read_enable: 2 edges (capture, then level register). Data on tx_tdata 2 edges later; total 4 cycles to first tx_tvalid.
- Sustained throughput: 1 word per cycle while tx_tready=1 and level>0.
- Back-pressure: with tx_tready=0, at most 2 words are fetched; read_enable then stays 0.
- read_pointer changes 1 cycle after the corresponding read_enable, and changes by one Gray bit per cycle.

## Configuration
- LOGIC_FIFO_GRAY_READ_CONTROLLER_ASSERTIONS_EN defined: SVA properties are compiled in and fire $error on violation:
  - write_pointer_synced changes by at most one bit per cycle.
  - level <= 2**ADDRESS_WIDTH.
  - tx_tdata and tx_tvalid are stable under back-pressure.
  - Skid buffer never overflows.
- Not defined: no assertion code; functional behaviour is identical.

## Structure
- bin2gray/gray2bin functions (parameterized width) go in the shared logic_pkg.
- Buffer state enum (EMPTY/ONE/TWO) goes in logic_pkg as a typedef.
- One sub-module: logic_fifo_gray_read_controller_buffer. It is the 2-entry skid buffer with the inflight flag and tx handshake. The top level holds the pointers and level.

## Test plan
All cases use DATA_WIDTH=8, ADDRESS_WIDTH=2.
- **Reset.** Hold reset 3 cycles with write_pointer_synced=3'b000 -> all outputs 0, read_enable never asserted.
- **Single word.** write_pointer_synced 3'b000->3'b001, memory returns 8'hA5 at address 0 -> read_enable at +2 cycles with read_address=0; tx_tvalid=1, tx_tdata=8'hA5 at +4; read_pointer becomes 3'b001.
- **Full burst.** write_pointer_synced=3'b110 (bin 4), tx_tready=1 -> 4 consecutive beats with data 0x10,0x11,0x12,0x13; read_pointer sequence 001,011,010,110; level ends at 0.
- **Back-pressure.** 4 entries available, tx_tready=0 -> exactly 2 read_enables, tx_tdata held at the first word; release tx_tready -> remaining 2 words arrive in order, none lost or duplicated.
- **Wrap.** Stream 10 words with the writer model advancing the pointer -> rp_bin wraps 7->0 (Gray 100->000); output order matches input 0..9.
- **Reset mid-burst.** Assert reset while tx_tvalid=1 and inflight=1 -> next cycle tx_tvalid=0, read_pointer=0, level=0; a post-reset single write is delivered correctly.
